lsu_tag_matcher: RTL and testbench

LSU_TAG_MATCHER -- requirements
Module: lsu_tag_matcher

---
 rtl/lsu_match_pkg.sv | 24 ++
 rtl/lsu_tag_cam.sv | 95 +++++++++
 rtl/lsu_tag_matcher.sv | 177 +++++++++++++++++
 tb/tb_lsu_tag_matcher.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_match_pkg.sv
// ----------------------------------------------------------------------------
// lsu_match_pkg
// Shared constants and types for the LSU tag matcher.
//   TAG_WIDTH_DEF / DEPTH_DEF / ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default
//     parameter values for lsu_tag_matcher and lsu_tag_cam.
//   TAG_WIDTH_MAX : storage width of the tag field in a table entry; the
//     configured TAG_WIDTH is zero-extended into it (TAG_WIDTH <= 32).
//   cam_entry_t   : one outstanding-instruction entry {valid, tag, is_write}.
// ----------------------------------------------------------------------------
package lsu_match_pkg;

  localparam int TAG_WIDTH_DEF  = 10;
  localparam int DEPTH_DEF      = 4;
  localparam int ADDR_WIDTH_DEF = 64;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int TAG_WIDTH_MAX  = 32;

  typedef struct packed {
    logic                     valid;
    logic [TAG_WIDTH_MAX-1:0] tag;
    logic                     is_write;
  } cam_entry_t;

endpackage

// File: rtl/lsu_tag_cam.sv
// ----------------------------------------------------------------------------
// lsu_tag_cam
// DEPTH-entry table of outstanding instruction tags.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   instr_tag_i         : tag looked up for the instruction port; also the
//                         tag written on allocation
//   instr_hit_o         : some live entry holds instr_tag_i
//   data_tag_i          : tag looked up for the data port
//   data_hit_o          : some live entry holds data_tag_i
//   data_idx_o          : index of that entry
//   data_is_write_o     : is_write recorded in that entry
//   alloc_en_i          : allocate lowest-index free entry with
//                         {instr_tag_i, alloc_is_write_i}
//   alloc_is_write_i    : is_write for the allocated entry
//   free_en_i           : invalidate the entry at data_idx_o
// Live tags are unique (the caller refuses duplicates), so at most one entry
// can match either lookup.
// ----------------------------------------------------------------------------
module lsu_tag_cam
  import lsu_match_pkg::*;
#(
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [TAG_WIDTH-1:0] instr_tag_i,
  output logic                 instr_hit_o,
  input  logic [TAG_WIDTH-1:0] data_tag_i,
  output logic                 data_hit_o,
  output logic [IDX_W-1:0]     data_idx_o,
  output logic                 data_is_write_o,
  input  logic                 alloc_en_i,
  input  logic                 alloc_is_write_i,
  input  logic                 free_en_i
);

  cam_entry_t entries_q [DEPTH];
  cam_entry_t entries_d [DEPTH];

  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_found;

  // Lookups and lowest-free search.
  always_comb begin
    instr_hit_o     = 1'b0;
    data_hit_o      = 1'b0;
    data_idx_o      = '0;
    data_is_write_o = 1'b0;
    alloc_idx       = '0;
    alloc_found     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && entries_q[i].tag == TAG_WIDTH_MAX'(instr_tag_i)) begin
        instr_hit_o = 1'b1;
      end
      if (entries_q[i].valid && entries_q[i].tag == TAG_WIDTH_MAX'(data_tag_i)) begin
        data_hit_o      = 1'b1;
        data_idx_o      = IDX_W'(i);
        data_is_write_o = entries_q[i].is_write;
      end
      if (!entries_q[i].valid && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  // The freed entry is live and the allocated one is free, so the two
  // indices never collide; a freed slot is only seen as free next cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    if (free_en_i) begin
      entries_d[data_idx_o].valid = 1'b0;
    end
    if (alloc_en_i) begin
      entries_d[alloc_idx] = '{valid: 1'b1,
                               tag: TAG_WIDTH_MAX'(instr_tag_i),
                               is_write: alloc_is_write_i};
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst_i) begin
        entries_q[i] <= '0;
      end else begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule

// File: rtl/lsu_tag_matcher.sv
// ----------------------------------------------------------------------------
// lsu_tag_matcher
// Pairs processor instructions {tag, is_write} with later data beats
// {tag, addr, value} and issues one memory request per pair; forwards memory
// completions back to the processor one cycle later.
//   clk, rst                          : clock, synchronous active-high reset
//   cs_N                              : active-low select; high blocks new
//                                       instruction/data acceptance only
//   lsu_proc_instr_* (valid/ready/tag/is_write) : instruction port
//   lsu_proc_data_*  (valid/ready/tag), lsu_proc_addr, lsu_proc_value : data
//   mem_req_* (valid/ready/is_write/tag/addr/value) : request output register
//   mem_cpl_* (valid/tag/value)       : completions in (no backpressure)
//   lsu_completion_* (valid/tag/value): registered completions out
//   pending_count                     : number of live table entries
// Optional feature: define LSU_TAG_MATCHER_BYPASS_EN to let an instruction
// and its data with the same tag pass straight through in one cycle.
//
// Handshakes: a transfer happens on a posedge where valid and ready are both
// high; nothing else moves data. mem_req_* is an output register that holds
// its contents while mem_req_valid is high and mem_req_ready is low.
// ----------------------------------------------------------------------------
module lsu_tag_matcher
  import lsu_match_pkg::*;
#(
  parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cs_N,
  input  logic                         lsu_proc_instr_valid,
  output logic                         lsu_proc_instr_ready,
  input  logic [TAG_WIDTH-1:0]         lsu_proc_instr_tag,
  input  logic                         lsu_proc_instr_is_write,
  input  logic                         lsu_proc_data_valid,
  output logic                         lsu_proc_data_ready,
  input  logic [TAG_WIDTH-1:0]         lsu_proc_data_tag,
  input  logic [ADDR_WIDTH-1:0]        lsu_proc_addr,
  input  logic [DATA_WIDTH-1:0]        lsu_proc_value,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_is_write,
  output logic [TAG_WIDTH-1:0]         mem_req_tag,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  output logic [DATA_WIDTH-1:0]        mem_req_value,
  input  logic                         mem_cpl_valid,
  input  logic [TAG_WIDTH-1:0]         mem_cpl_tag,
  input  logic [DATA_WIDTH-1:0]        mem_cpl_value,
  output logic                         lsu_completion_valid,
  output logic [TAG_WIDTH-1:0]         lsu_completion_tag,
  output logic [DATA_WIDTH-1:0]        lsu_completion_value,
  output logic [$clog2(DEPTH+1)-1:0]   pending_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic                  instr_hit, data_hit, data_is_write;
  logic [IDX_W-1:0]      data_idx;
  logic                  out_free, not_full, bypass;
  logic                  instr_fire, data_fire, alloc_en, free_en;

  logic [CNT_W-1:0]      pending_q, pending_d;
  logic                  req_valid_q, req_valid_d;
  logic                  req_is_write_q, req_is_write_d;
  logic [TAG_WIDTH-1:0]  req_tag_q, req_tag_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_value_q, req_value_d;
  logic                  cpl_valid_q;
  logic [TAG_WIDTH-1:0]  cpl_tag_q;
  logic [DATA_WIDTH-1:0] cpl_value_q;

  lsu_tag_cam #(
    .TAG_WIDTH (TAG_WIDTH),
    .DEPTH     (DEPTH)
  ) u_cam (
    .clk_i            (clk),
    .rst_i            (rst),
    .instr_tag_i      (lsu_proc_instr_tag),
    .instr_hit_o      (instr_hit),
    .data_tag_i       (lsu_proc_data_tag),
    .data_hit_o       (data_hit),
    .data_idx_o       (data_idx),
    .data_is_write_o  (data_is_write),
    .alloc_en_i       (alloc_en),
    .alloc_is_write_i (lsu_proc_instr_is_write),
    .free_en_i        (free_en)
  );

  // The request register can take a new beat if it is empty or draining now.
  assign out_free = !req_valid_q || mem_req_ready;
  assign not_full = pending_q < CNT_W'(DEPTH);

`ifdef LSU_TAG_MATCHER_BYPASS_EN
  // Same-tag instruction and data meet in one cycle: the pair goes straight
  // to the request register without touching the table, so a full table
  // does not block it.
  assign bypass = !rst && !cs_N && out_free &&
                  lsu_proc_instr_valid && lsu_proc_data_valid &&
                  (lsu_proc_instr_tag == lsu_proc_data_tag) && !instr_hit;
`else
  assign bypass = 1'b0;
`endif

  // instr_hit also covers an entry freed this very cycle, so a reused tag is
  // refused until the free has landed.
  assign lsu_proc_instr_ready = !rst && !cs_N && !instr_hit && (not_full || bypass);
  assign lsu_proc_data_ready  = !rst && !cs_N && out_free && (data_hit || bypass);

  assign instr_fire = lsu_proc_instr_valid && lsu_proc_instr_ready;
  assign data_fire  = lsu_proc_data_valid && lsu_proc_data_ready;
  assign alloc_en   = instr_fire && !bypass;
  assign free_en    = data_fire && !bypass;

  always_comb begin
    pending_d = pending_q;
    case ({alloc_en, free_en})
      2'b10:   pending_d = pending_q + CNT_W'(1);
      2'b01:   pending_d = pending_q - CNT_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_comb begin
    req_valid_d    = req_valid_q;
    req_is_write_d = req_is_write_q;
    req_tag_d      = req_tag_q;
    req_addr_d     = req_addr_q;
    req_value_d    = req_value_q;
    if (data_fire) begin
      req_valid_d    = 1'b1;
      req_is_write_d = bypass ? lsu_proc_instr_is_write : data_is_write;
      req_tag_d      = lsu_proc_data_tag;
      req_addr_d     = lsu_proc_addr;
      req_value_d    = lsu_proc_value;
    end else if (mem_req_ready) begin
      req_valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= '0;
      req_valid_q    <= 1'b0;
      req_is_write_q <= 1'b0;
      req_tag_q      <= '0;
      req_addr_q     <= '0;
      req_value_q    <= '0;
      cpl_valid_q    <= 1'b0;
      cpl_tag_q      <= '0;
      cpl_value_q    <= '0;
    end else begin
      pending_q      <= pending_d;
      req_valid_q    <= req_valid_d;
      req_is_write_q <= req_is_write_d;
      req_tag_q      <= req_tag_d;
      req_addr_q     <= req_addr_d;
      req_value_q    <= req_value_d;
      cpl_valid_q    <= mem_cpl_valid;
      cpl_tag_q      <= mem_cpl_tag;
      cpl_value_q    <= mem_cpl_value;
    end
  end

  assign pending_count        = pending_q;
  assign mem_req_valid        = req_valid_q;
  assign mem_req_is_write     = req_is_write_q;
  assign mem_req_tag          = req_tag_q;
  assign mem_req_addr         = req_addr_q;
  assign mem_req_value        = req_value_q;
  assign lsu_completion_valid = cpl_valid_q;
  assign lsu_completion_tag   = cpl_tag_q;
  assign lsu_completion_value = cpl_value_q;

endmodule

// File: tb/tb_lsu_tag_matcher.sv
// ----------------------------------------------------------------------------
// tb_lsu_tag_matcher
// Bench for lsu_tag_matcher (default parameters). Expected memory requests and
// completions go into queues when stimulus is accepted and are popped by a
// monitor when the DUT transfers them. Honours LSU_TAG_MATCHER_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_lsu_tag_matcher;

  localparam int TW     = 10;
  localparam int AW     = 64;
  localparam int DW     = 64;
  localparam int CW     = 3;
  localparam int REQ_W  = 1 + TW + AW + DW;
  localparam int CPL_W  = TW + DW;
  localparam int BUDGET = 50;
  localparam int NVEC   = 5;

  logic          clk;
  logic          rst;
  logic          cs_N;
  logic          lsu_proc_instr_valid, lsu_proc_instr_ready;
  logic [TW-1:0] lsu_proc_instr_tag;
  logic          lsu_proc_instr_is_write;
  logic          lsu_proc_data_valid, lsu_proc_data_ready;
  logic [TW-1:0] lsu_proc_data_tag;
  logic [AW-1:0] lsu_proc_addr;
  logic [DW-1:0] lsu_proc_value;
  logic          mem_req_valid, mem_req_ready, mem_req_is_write;
  logic [TW-1:0] mem_req_tag;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_value;
  logic          mem_cpl_valid;
  logic [TW-1:0] mem_cpl_tag;
  logic [DW-1:0] mem_cpl_value;
  logic          lsu_completion_valid;
  logic [TW-1:0] lsu_completion_tag;
  logic [DW-1:0] lsu_completion_value;
  logic [CW-1:0] pending_count;

  lsu_tag_matcher dut (
    .clk                     (clk),
    .rst                     (rst),
    .cs_N                    (cs_N),
    .lsu_proc_instr_valid    (lsu_proc_instr_valid),
    .lsu_proc_instr_ready    (lsu_proc_instr_ready),
    .lsu_proc_instr_tag      (lsu_proc_instr_tag),
    .lsu_proc_instr_is_write (lsu_proc_instr_is_write),
    .lsu_proc_data_valid     (lsu_proc_data_valid),
    .lsu_proc_data_ready     (lsu_proc_data_ready),
    .lsu_proc_data_tag       (lsu_proc_data_tag),
    .lsu_proc_addr           (lsu_proc_addr),
    .lsu_proc_value          (lsu_proc_value),
    .mem_req_valid           (mem_req_valid),
    .mem_req_ready           (mem_req_ready),
    .mem_req_is_write        (mem_req_is_write),
    .mem_req_tag             (mem_req_tag),
    .mem_req_addr            (mem_req_addr),
    .mem_req_value           (mem_req_value),
    .mem_cpl_valid           (mem_cpl_valid),
    .mem_cpl_tag             (mem_cpl_tag),
    .mem_cpl_value           (mem_cpl_value),
    .lsu_completion_valid    (lsu_completion_valid),
    .lsu_completion_tag      (lsu_completion_tag),
    .lsu_completion_value    (lsu_completion_value),
    .pending_count           (pending_count)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [REQ_W-1:0] exp_q[$];
  logic [CPL_W-1:0] cpl_q[$];
  logic [REQ_W-1:0] mon_req_got, mon_req_exp;
  logic [CPL_W-1:0] mon_cpl_got, mon_cpl_exp;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs only change at negedge (+0/+1) or posedge+1, so negedge+2 sees the
  // values that the following posedge will transfer.
  always @(negedge clk) begin
    #2;
    if (!rst && mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
      mon_req_got = {mem_req_is_write, mem_req_tag, mem_req_addr, mem_req_value};
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mem_req_unexpected: got %0h expected none", mon_req_got);
      end else begin
        mon_req_exp = exp_q.pop_front();
        check("mem_req_content", mon_req_got, mon_req_exp);
      end
    end
    if (!rst && lsu_completion_valid === 1'b1) begin
      mon_cpl_got = {lsu_completion_tag, lsu_completion_value};
      if (cpl_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL completion_unexpected: got %0h expected none", mon_cpl_got);
      end else begin
        mon_cpl_exp = cpl_q.pop_front();
        check("completion_content", mon_cpl_got, mon_cpl_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_instr(input logic [TW-1:0] tag, input logic wr);
    int n;
    n = 0;
    @(negedge clk);
    lsu_proc_instr_valid    = 1'b1;
    lsu_proc_instr_tag      = tag;
    lsu_proc_instr_is_write = wr;
    #1;
    while (!lsu_proc_instr_ready && n < BUDGET) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("instr_accept_timeout", lsu_proc_instr_ready, 1);
    @(posedge clk);
    #1;
    lsu_proc_instr_valid = 1'b0;
  endtask

  task automatic send_data(input logic [TW-1:0] tag, input logic [AW-1:0] addr,
                           input logic [DW-1:0] value, input logic [REQ_W-1:0] exp,
                           input bit do_push);
    int n;
    n = 0;
    @(negedge clk);
    lsu_proc_data_valid = 1'b1;
    lsu_proc_data_tag   = tag;
    lsu_proc_addr       = addr;
    lsu_proc_value      = value;
    #1;
    while (!lsu_proc_data_ready && n < BUDGET) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("data_accept_timeout", lsu_proc_data_ready, 1);
    if (lsu_proc_data_ready && do_push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    lsu_proc_data_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [TW-1:0]    tag;
    logic             wr;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    value;
    logic [REQ_W-1:0] exp_req;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_rdy;
  logic [REQ_W-1:0] e8, e9;

  initial begin
    rst = 1'b1; cs_N = 1'b0;
    lsu_proc_instr_valid = 1'b0; lsu_proc_instr_tag = '0; lsu_proc_instr_is_write = 1'b0;
    lsu_proc_data_valid = 1'b0; lsu_proc_data_tag = '0; lsu_proc_addr = '0; lsu_proc_value = '0;
    mem_req_ready = 1'b1; mem_cpl_valid = 1'b0; mem_cpl_tag = '0; mem_cpl_value = '0;

    vecs[0] = '{tag: 10'd10,  wr: 1'b1, addr: 64'h1000, value: 64'hDEADBEEFCAFEF00D, exp_req: '0};
    vecs[1] = '{tag: 10'd0,   wr: 1'b0, addr: 64'h0,    value: 64'h0,                exp_req: '0};
    vecs[2] = '{tag: 10'h3FF, wr: 1'b1, addr: '1,       value: '1,                   exp_req: '0};
    vecs[3] = '{tag: 10'h155, wr: 1'b0, addr: 64'h8000_0000_0000_0008,
                value: 64'h0123_4567_89AB_CDEF, exp_req: '0};
    vecs[4] = '{tag: 10'h2AA, wr: 1'b1, addr: {$urandom, $urandom},
                value: {$urandom, $urandom}, exp_req: '0};
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].exp_req = {vecs[i].wr, vecs[i].tag, vecs[i].addr, vecs[i].value};
    end

    // ---- reset: readies low while rst is high, outputs cleared ----
    @(negedge clk);
    lsu_proc_instr_valid = 1'b1; lsu_proc_instr_tag = 10'd3;
    lsu_proc_data_valid = 1'b1; lsu_proc_data_tag = 10'd3;
    #1;
    check("rst_instr_ready", lsu_proc_instr_ready, 0);
    check("rst_data_ready", lsu_proc_data_ready, 0);
    @(negedge clk);
    #1;
    check("rst_outputs", {mem_req_valid, mem_req_is_write, mem_req_tag, mem_req_addr,
                          mem_req_value, lsu_completion_valid, lsu_completion_tag,
                          lsu_completion_value, pending_count}, 0);
    lsu_proc_instr_valid = 1'b0; lsu_proc_data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // ---- table: single instruction/data pairs ----
    for (int i = 0; i < NVEC; i++) begin
      send_instr(vecs[i].tag, vecs[i].wr);
      @(negedge clk); #1;
      check("vec_pending_after_instr", pending_count, 1);
      send_data(vecs[i].tag, vecs[i].addr, vecs[i].value, vecs[i].exp_req, 1'b1);
      @(negedge clk); #1;
      check("vec_req_valid_latency", mem_req_valid, 1);
      check("vec_pending_after_data", pending_count, 0);
      @(negedge clk); #1;
      check("vec_req_valid_drop", mem_req_valid, 0);
    end

    // ---- full table, out-of-order data, same-cycle free/alloc ----
    for (int t = 1; t <= 4; t++) send_instr(TW'(t), (t % 2) == 1);
    @(negedge clk);
    lsu_proc_instr_valid = 1'b1; lsu_proc_instr_tag = 10'd5; lsu_proc_instr_is_write = 1'b0;
    lsu_proc_data_valid = 1'b1; lsu_proc_data_tag = 10'd4;
    lsu_proc_addr = 64'h4444; lsu_proc_value = 64'h4040;
    #1;
    check("full_pending", pending_count, 4);
    check("full_instr_refused", lsu_proc_instr_ready, 0);
    check("full_data_ready", lsu_proc_data_ready, 1);
    exp_q.push_back({1'b0, 10'd4, 64'h4444, 64'h4040});
    @(posedge clk); #1;
    lsu_proc_data_valid = 1'b0;
    @(negedge clk); #1;
    check("freed_entry_alloc", lsu_proc_instr_ready, 1);
    @(posedge clk); #1;
    lsu_proc_instr_valid = 1'b0;
    @(negedge clk);
    lsu_proc_instr_valid = 1'b1; lsu_proc_instr_tag = 10'd2;
    lsu_proc_data_valid = 1'b1; lsu_proc_data_tag = 10'd2;
    lsu_proc_addr = 64'h2222; lsu_proc_value = 64'h2020;
    #1;
    check("freeing_tag_refused", lsu_proc_instr_ready, 0);
    check("freeing_tag_data_ready", lsu_proc_data_ready, 1);
    exp_q.push_back({1'b0, 10'd2, 64'h2222, 64'h2020});
    @(posedge clk); #1;
    lsu_proc_instr_valid = 1'b0; lsu_proc_data_valid = 1'b0;
    @(negedge clk); #1;
    check("pending_after_two_frees", pending_count, 3);
    send_data(10'd1, 64'h1111, 64'h1010, {1'b1, 10'd1, 64'h1111, 64'h1010}, 1'b1);
    send_data(10'd3, 64'h3333, 64'h3030, {1'b1, 10'd3, 64'h3333, 64'h3030}, 1'b1);
    send_data(10'd5, 64'h5555, 64'h5050, {1'b0, 10'd5, 64'h5555, 64'h5050}, 1'b1);
    @(negedge clk); #1;
    check("pending_drained", pending_count, 0);

    // ---- orphan data waits for its instruction ----
    @(negedge clk);
    lsu_proc_data_valid = 1'b1; lsu_proc_data_tag = 10'd7;
    lsu_proc_addr = 64'h7777; lsu_proc_value = 64'h7070;
    n_rdy = 0;
    repeat (10) begin
      #1;
      if (lsu_proc_data_ready) n_rdy++;
      @(negedge clk);
    end
    check("orphan_data_stalled", n_rdy, 0);
    lsu_proc_instr_valid = 1'b1; lsu_proc_instr_tag = 10'd7; lsu_proc_instr_is_write = 1'b1;
    #1;
    check("orphan_instr_ready", lsu_proc_instr_ready, 1);
`ifdef LSU_TAG_MATCHER_BYPASS_EN
    check("bypass_same_cycle", lsu_proc_data_ready, 1);
    exp_q.push_back({1'b1, 10'd7, 64'h7777, 64'h7070});
    @(posedge clk); #1;
    lsu_proc_instr_valid = 1'b0; lsu_proc_data_valid = 1'b0;
`else
    check("no_bypass_same_cycle", lsu_proc_data_ready, 0);
    @(posedge clk); #1;
    lsu_proc_instr_valid = 1'b0;
    @(negedge clk); #1;
    check("data_after_instr", lsu_proc_data_ready, 1);
    exp_q.push_back({1'b1, 10'd7, 64'h7777, 64'h7070});
    @(posedge clk); #1;
    lsu_proc_data_valid = 1'b0;
`endif
    @(negedge clk); #1;
    check("orphan_pending", pending_count, 0);

    // ---- backpressure: held request, second data stalled, cs_N ----
    send_instr(10'd8, 1'b1);
    send_instr(10'd9, 1'b0);
    @(negedge clk);
    mem_req_ready = 1'b0;
    e8 = {1'b1, 10'd8, 64'hA8, 64'hB8};
    e9 = {1'b0, 10'd9, 64'hA9, 64'hB9};
    send_data(10'd8, 64'hA8, 64'hB8, e8, 1'b1);
    @(negedge clk);
    lsu_proc_data_valid = 1'b1; lsu_proc_data_tag = 10'd9;
    lsu_proc_addr = 64'hA9; lsu_proc_value = 64'hB9;
    repeat (5) begin
      #1;
      check("held_req_stable", {mem_req_valid, mem_req_is_write, mem_req_tag,
                                mem_req_addr, mem_req_value}, {1'b1, e8});
      check("second_data_stalled", lsu_proc_data_ready, 0);
      @(negedge clk);
    end
    cs_N = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    check("cs_blocks_data", lsu_proc_data_ready, 0);
    @(negedge clk);
    cs_N = 1'b0;
    #1;
    check("held_req_drained_under_cs", mem_req_valid, 0);
    check("second_data_ready", lsu_proc_data_ready, 1);
    exp_q.push_back(e9);
    @(posedge clk); #1;
    lsu_proc_data_valid = 1'b0;
    @(negedge clk); #1;
    check("backpressure_pending", pending_count, 0);

    // ---- completion forwarding (with cs_N high) ----
    @(negedge clk);
    cs_N = 1'b1;
    mem_cpl_valid = 1'b1; mem_cpl_tag = 10'd20; mem_cpl_value = 64'h1234_5678_9ABC_DEF0;
    cpl_q.push_back({10'd20, 64'h1234_5678_9ABC_DEF0});
    @(negedge clk);
    mem_cpl_tag = 10'd21; mem_cpl_value = 64'hFEDC_BA98_7654_3210;
    cpl_q.push_back({10'd21, 64'hFEDC_BA98_7654_3210});
    @(negedge clk);
    mem_cpl_valid = 1'b0;
    @(negedge clk); #1;
    check("completion_one_cycle", lsu_completion_valid, 0);
    cs_N = 1'b0;

    // ---- reset mid-operation ----
    for (int t = 11; t <= 14; t++) send_instr(TW'(t), 1'b1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    send_data(10'd14, 64'hE14, 64'hF14, '0, 1'b0);
    @(negedge clk); #1;
    check("pre_reset_pending", pending_count, 3);
    check("pre_reset_req_held", mem_req_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_outputs", {mem_req_valid, mem_req_is_write, mem_req_tag, mem_req_addr,
                             mem_req_value, lsu_completion_valid, lsu_completion_tag,
                             lsu_completion_value, pending_count}, 0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    lsu_proc_data_valid = 1'b1; lsu_proc_data_tag = 10'd11;
    #1;
    check("midrst_entries_gone", lsu_proc_data_ready, 0);
    @(posedge clk); #1;
    lsu_proc_data_valid = 1'b0;

    // ---- same-tag instruction + data on a full table ----
    for (int t = 21; t <= 24; t++) send_instr(TW'(t), 1'b0);
    @(negedge clk);
    lsu_proc_instr_valid = 1'b1; lsu_proc_instr_tag = 10'd5; lsu_proc_instr_is_write = 1'b1;
    lsu_proc_data_valid = 1'b1; lsu_proc_data_tag = 10'd5;
    lsu_proc_addr = 64'h5A5A; lsu_proc_value = 64'hC0FFEE;
    #1;
`ifdef LSU_TAG_MATCHER_BYPASS_EN
    check("bypass_full_instr_ready", lsu_proc_instr_ready, 1);
    check("bypass_full_data_ready", lsu_proc_data_ready, 1);
    exp_q.push_back({1'b1, 10'd5, 64'h5A5A, 64'hC0FFEE});
    @(posedge clk); #1;
    lsu_proc_instr_valid = 1'b0; lsu_proc_data_valid = 1'b0;
    @(negedge clk); #1;
    check("bypass_req_next_cycle", {mem_req_valid, mem_req_tag}, {1'b1, 10'd5});
`else
    check("full_no_bypass_instr", lsu_proc_instr_ready, 0);
    check("full_no_bypass_data", lsu_proc_data_ready, 0);
    @(posedge clk); #1;
    lsu_proc_instr_valid = 1'b0; lsu_proc_data_valid = 1'b0;
    @(negedge clk); #1;
    check("full_no_bypass_req", mem_req_valid, 0);
`endif
    check("full_pending_kept", pending_count, 4);

    // ---- final report ----
    repeat (3) @(negedge clk);
    #3;
    check("req_queue_drained", exp_q.size(), 0);
    check("cpl_queue_drained", cpl_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
